// File: rtl/fetch_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_buffer_if
//  Purpose  : Bundles the instruction-memory request/response channel and the
//             decode-side channel (redirect, stall, head instruction) of the
//             fetch buffer.
//  Modports : master - fetch buffer side (drives imem_req/imem_addr and the
//                      decode outputs instrD/pcplus4D/validD)
//             slave  - environment side (memory + decode/branch logic)
//  Revision : 1.0 - initial release
// ============================================================================
interface fetch_buffer_if #(
    parameter int WIDTH = 32
);
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ack;
    logic [WIDTH-1:0] imem_rdata;
    logic             redirect;
    logic [WIDTH-1:0] redirect_pc;
    logic             stallD;
    logic [WIDTH-1:0] instrD;
    logic [WIDTH-1:0] pcplus4D;
    logic             validD;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        input  redirect, redirect_pc, stallD,
        output instrD, pcplus4D, validD
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        output redirect, redirect_pc, stallD,
        input  instrD, pcplus4D, validD
    );
endinterface
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_buffer
//  Purpose  : Instruction prefetch buffer. Issues one instruction-memory
//             request at a time, queues responses as {instr, addr+4} in a
//             DEPTH-entry FIFO and presents the head entry to decode.
//             A redirect flushes the FIFO and restarts fetch at redirect_pc;
//             a response still in flight at that moment is discarded.
//  Ports    : clk    - clock, rising edge
//             reset  - asynchronous, active-low reset
//             bus    - fetch_buffer_if.master (imem_req/addr/ack/rdata,
//                      redirect/redirect_pc, stallD, instrD/pcplus4D/validD)
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_buffer #(
    parameter int               WIDTH   = 32,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RESETPC = '0
) (
    input wire             clk,
    input wire             reset,
    fetch_buffer_if.master bus
);

    localparam int               PW        = $clog2(DEPTH);
    localparam logic [PW:0]      c_DEPTH   = (PW+1)'(DEPTH);
    localparam logic [WIDTH-1:0] c_PC_STEP = WIDTH'(4);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_fpc;
    logic [WIDTH-1:0] r_reqAddr;
    logic             r_busy;
    logic             r_drop;
    logic [PW:0]      r_count;
    logic [PW-1:0]    r_rdPtr;
    logic [PW-1:0]    r_wrPtr;
    logic [WIDTH-1:0] r_instrMem [DEPTH];
    logic [WIDTH-1:0] r_pcMem    [DEPTH];
    logic [WIDTH-1:0] r_instrD;
    logic [WIDTH-1:0] r_pcplus4D;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic             w_flush;
    logic             w_ackValid;
    logic             w_push;
    logic             w_pop;
    logic             w_canIssue;
    logic [WIDTH-1:0] w_ackPcPlus4;
    logic [PW:0]      w_countAfterPop;
    logic [PW-1:0]    w_rdPtrNext;

    always_comb begin
        w_flush      = bus.redirect;
        // An ack with nothing outstanding is a protocol error and is ignored.
        w_ackValid   = bus.imem_ack & r_busy;
        w_ackPcPlus4 = r_reqAddr + c_PC_STEP;
        w_push       = w_ackValid & ~r_drop & ~w_flush;
        w_pop        = (r_count != '0) & ~bus.stallD & ~w_flush;
        // Only one request is ever outstanding and the ack pushes in the same
        // edge that clears busy, so with busy=0 nothing is in flight and the
        // occupancy alone decides whether there is room. A redirect cycle
        // never issues: fpc is stale until the redirect edge. Reset gates the
        // request so imem_req is low while reset is held.
        w_canIssue   = reset & ~r_busy & ~w_flush & (r_count < c_DEPTH);
        w_countAfterPop = r_count - (PW+1)'(w_pop);
        w_rdPtrNext     = r_rdPtr + PW'(w_pop);
    end

    assign bus.imem_req  = r_busy | w_canIssue;
    assign bus.imem_addr = r_busy ? r_reqAddr : r_fpc;
    assign bus.validD    = (r_count != '0);
    assign bus.instrD    = r_instrD;
    assign bus.pcplus4D  = r_pcplus4D;

    // ------------------------------------------------------------------
    // Fetch control, FIFO bookkeeping and registered head copy
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fpc      <= RESETPC;
            r_reqAddr  <= RESETPC;
            r_busy     <= 1'b0;
            r_drop     <= 1'b0;
            r_count    <= '0;
            r_rdPtr    <= '0;
            r_wrPtr    <= '0;
            r_instrD   <= '0;
            r_pcplus4D <= '0;
        end else begin
            if (w_flush) begin
                r_fpc <= bus.redirect_pc;
            end else if (w_push) begin
                r_fpc <= w_ackPcPlus4;
            end

            if (w_canIssue) begin
                r_busy    <= 1'b1;
                r_reqAddr <= r_fpc;
            end else if (w_ackValid) begin
                r_busy <= 1'b0;
            end

            // drop marks the outstanding response as wrong-path; an ack
            // coinciding with the redirect is discarded directly instead.
            if (w_ackValid) begin
                r_drop <= 1'b0;
            end else if (w_flush && r_busy) begin
                r_drop <= 1'b1;
            end

            if (w_flush) begin
                r_count <= '0;
                r_rdPtr <= '0;
                r_wrPtr <= '0;
            end else begin
                r_count <= w_countAfterPop + (PW+1)'(w_push);
                r_rdPtr <= w_rdPtrNext;
                if (w_push) begin
                    r_wrPtr <= r_wrPtr + PW'(1);
                end
            end

            // Head copy: if entries survive the pop, the new head is already
            // in storage; otherwise the incoming push becomes the head. With
            // nothing to show, the last head values are kept.
            if (!w_flush) begin
                if (w_countAfterPop != '0) begin
                    r_instrD   <= r_instrMem[w_rdPtrNext];
                    r_pcplus4D <= r_pcMem[w_rdPtrNext];
                end else if (w_push) begin
                    r_instrD   <= bus.imem_rdata;
                    r_pcplus4D <= w_ackPcPlus4;
                end
            end
        end
    end

    // FIFO storage needs no reset: an entry is only read after being written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instrMem[r_wrPtr] <= bus.imem_rdata;
            r_pcMem[r_wrPtr]    <= w_ackPcPlus4;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_buffer
//  Purpose  : Directed self-checking bench for fetch_buffer. A 32-bit instance
//             (RESETPC=0) covers streaming, back-pressure, redirects and
//             reset; a 16-bit instance (RESETPC=FFFC) covers address wrap.
//             Inputs change 1 time unit after the rising edge; outputs are
//             sampled on the falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_buffer;

    logic clk = 1'b0;
    logic resetN;
    int   checks = 0;
    int   errors = 0;

    fetch_buffer_if #(.WIDTH(32)) bus ();
    fetch_buffer_if #(.WIDTH(16)) bus16 ();

    fetch_buffer #(.WIDTH(32), .DEPTH(4), .RESETPC(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (resetN),
        .bus   (bus)
    );

    fetch_buffer #(.WIDTH(16), .DEPTH(4), .RESETPC(16'hFFFC)) dut16 (
        .clk   (clk),
        .reset (resetN),
        .bus   (bus16)
    );

    always #5 clk = ~clk;

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clearInputs();
        bus.imem_ack      = 1'b0;
        bus.imem_rdata    = '0;
        bus.redirect      = 1'b0;
        bus.redirect_pc   = '0;
        bus.stallD        = 1'b0;
        bus16.imem_ack    = 1'b0;
        bus16.imem_rdata  = '0;
        bus16.redirect    = 1'b0;
        bus16.redirect_pc = '0;
        bus16.stallD      = 1'b0;
    endtask

    // Leaves the bench 1 unit into the first cycle after reset release.
    task automatic restart();
        nextCycle();
        resetN = 1'b0;
        clearInputs();
        nextCycle();
        resetN = 1'b1;
    endtask

    // n fetches from address 0 with a 1-cycle memory; ends in the issue
    // cycle of address 4*n.
    task automatic fetchSeq(input int n, input logic [31:0] dbase);
        for (int k = 0; k < n; k++) begin
            sample();
            chk("seq_addr", bus.imem_addr, 32'(4 * k));
            nextCycle();
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = dbase | 32'(4 * k);
            nextCycle();
            bus.imem_ack   = 1'b0;
        end
    endtask

    initial begin
        resetN = 1'b1;
        clearInputs();
        #1 resetN = 1'b0;
        nextCycle();
        nextCycle();
        sample();
        chk("rst_req",     32'(bus.imem_req), 32'd0);
        chk("rst_addr",    bus.imem_addr,     32'h0);
        chk("rst_valid",   32'(bus.validD),   32'd0);
        chk("rst_instr",   bus.instrD,        32'h0);
        chk("rst_pc4",     bus.pcplus4D,      32'h0);
        chk("rst16_req",   32'(bus16.imem_req), 32'd0);
        chk("rst16_addr",  32'(bus16.imem_addr), 32'h0000_FFFC);

        // ---- streaming with 1-cycle memory, no stall -------------------
        nextCycle();
        resetN = 1'b1;
        sample();
        chk("s_req0",   32'(bus.imem_req), 32'd1);
        chk("s_addr0",  bus.imem_addr,     32'h0);
        chk("s_valid0", 32'(bus.validD),   32'd0);
        nextCycle();
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1000_0000;
        sample();
        chk("s_hold0",  bus.imem_addr, 32'h0);
        nextCycle();
        bus.imem_ack = 1'b0;
        sample();
        chk("s_valid1", 32'(bus.validD), 32'd1);
        chk("s_instr1", bus.instrD,      32'h1000_0000);
        chk("s_pc4_1",  bus.pcplus4D,    32'h4);
        chk("s_addr4",  bus.imem_addr,   32'h4);
        nextCycle();
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1000_0004;
        sample();
        chk("s_gap",    32'(bus.validD), 32'd0);
        chk("s_holdI",  bus.instrD,      32'h1000_0000);
        nextCycle();
        bus.imem_ack = 1'b0;
        sample();
        chk("s_pc4_2",  bus.pcplus4D,  32'h8);
        chk("s_instr2", bus.instrD,    32'h1000_0004);
        chk("s_addr8",  bus.imem_addr, 32'h8);
        nextCycle();
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1000_0008;
        nextCycle();
        bus.imem_ack = 1'b0;
        sample();
        chk("s_valid3", 32'(bus.validD), 32'd1);
        chk("s_pc4_3",  bus.pcplus4D,    32'hC);
        chk("s_instr3", bus.instrD,      32'h1000_0008);

        // ---- stall fills the FIFO, then drain --------------------------
        restart();
        bus.stallD = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k != 0) begin
                nextCycle();
                bus.imem_ack = 1'b0;
            end
            sample();
            chk("f_req",  32'(bus.imem_req), 32'd1);
            chk("f_addr", bus.imem_addr,     32'(4 * k));
            nextCycle();
            bus.imem_ack = 1'b1; bus.imem_rdata = 32'h2000_0000 | 32'(4 * k);
        end
        nextCycle();
        bus.imem_ack = 1'b0;
        sample();
        chk("f_full_req", 32'(bus.imem_req), 32'd0);
        chk("f_full_vld", 32'(bus.validD),   32'd1);
        nextCycle();
        sample();
        chk("f_full_req2", 32'(bus.imem_req), 32'd0);
        chk("f_full_pc4",  bus.pcplus4D,      32'h4);
        nextCycle();
        bus.stallD = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k != 0) nextCycle();
            sample();
            chk("d_valid", 32'(bus.validD),   32'd1);
            chk("d_pc4",   bus.pcplus4D,      32'(4 * k + 4));
            chk("d_instr", bus.instrD,        32'h2000_0000 | 32'(4 * k));
            chk("d_req",   32'(bus.imem_req), 32'(k != 0));
            if (k != 0) chk("d_addr", bus.imem_addr, 32'h10);
        end
        nextCycle();
        sample();
        chk("d_empty",   32'(bus.validD), 32'd0);
        chk("d_holdpc4", bus.pcplus4D,    32'h10);
        chk("d_holdI",   bus.instrD,      32'h2000_000C);

        // ---- redirect while busy, ack arrives 3 cycles later ----------
        restart();
        fetchSeq(2, 32'h1000_0000);
        sample();
        chk("r_addr8", bus.imem_addr, 32'h8);
        nextCycle();
        bus.redirect = 1'b1; bus.redirect_pc = 32'h100;
        sample();
        chk("r_req_redir",  32'(bus.imem_req), 32'd1);
        chk("r_addr_redir", bus.imem_addr,     32'h8);
        nextCycle();
        bus.redirect = 1'b0;
        sample();
        chk("r_addr_hold1", bus.imem_addr, 32'h8);
        nextCycle();
        sample();
        chk("r_addr_hold2", bus.imem_addr, 32'h8);
        nextCycle();
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_0008;
        sample();
        chk("r_addr_ack", bus.imem_addr, 32'h8);
        nextCycle();
        bus.imem_ack = 1'b0;
        sample();
        chk("r_dropped",  32'(bus.validD),   32'd0);
        chk("r_pc4_keep", bus.pcplus4D,      32'h8);
        chk("r_req_new",  32'(bus.imem_req), 32'd1);
        chk("r_addr_new", bus.imem_addr,     32'h100);
        nextCycle();
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h3000_0100;
        nextCycle();
        bus.imem_ack = 1'b0;
        sample();
        chk("r_valid", 32'(bus.validD), 32'd1);
        chk("r_pc4",   bus.pcplus4D,    32'h104);
        chk("r_instr", bus.instrD,      32'h3000_0100);

        // ---- redirect coincident with ack ------------------------------
        restart();
        fetchSeq(3, 32'h1000_0000);
        nextCycle();
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hBAD0_000C;
        bus.redirect = 1'b1; bus.redirect_pc = 32'h200;
        sample();
        chk("c_addrC", bus.imem_addr, 32'hC);
        nextCycle();
        bus.imem_ack = 1'b0; bus.redirect = 1'b0;
        sample();
        chk("c_nopush", 32'(bus.validD),   32'd0);
        chk("c_req",    32'(bus.imem_req), 32'd1);
        chk("c_addr",   bus.imem_addr,     32'h200);
        nextCycle();
        nextCycle();
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h4000_0200;
        nextCycle();
        bus.imem_ack = 1'b0;
        sample();
        chk("c_valid", 32'(bus.validD), 32'd1);
        chk("c_pc4",   bus.pcplus4D,    32'h204);

        // ---- reset mid-request, stray ack after release ---------------
        restart();
        fetchSeq(2, 32'h5000_0000);
        nextCycle();
        resetN = 1'b0;
        sample();
        chk("m_req",   32'(bus.imem_req), 32'd0);
        chk("m_addr",  bus.imem_addr,     32'h0);
        chk("m_valid", 32'(bus.validD),   32'd0);
        chk("m_instr", bus.instrD,        32'h0);
        chk("m_pc4",   bus.pcplus4D,      32'h0);
        nextCycle();
        resetN = 1'b1;
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hBAD0_0008;
        sample();
        chk("m_first_req",  32'(bus.imem_req), 32'd1);
        chk("m_first_addr", bus.imem_addr,     32'h0);
        nextCycle();
        bus.imem_ack = 1'b0;
        sample();
        chk("m_stray_ign", 32'(bus.validD), 32'd0);
        chk("m_busy_addr", bus.imem_addr,   32'h0);
        nextCycle();
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h6000_0000;
        nextCycle();
        bus.imem_ack = 1'b0;
        sample();
        chk("m_valid2", 32'(bus.validD), 32'd1);
        chk("m_pc4_2",  bus.pcplus4D,    32'h4);
        chk("m_instr2", bus.instrD,      32'h6000_0000);

        // ---- 16-bit address wrap ---------------------------------------
        restart();
        sample();
        chk("w_req",  32'(bus16.imem_req),  32'd1);
        chk("w_addr", 32'(bus16.imem_addr), 32'h0000_FFFC);
        nextCycle();
        bus16.imem_ack = 1'b1; bus16.imem_rdata = 16'hABCD;
        nextCycle();
        bus16.imem_ack = 1'b0;
        sample();
        chk("w_addr_wrap", 32'(bus16.imem_addr), 32'h0);
        chk("w_valid",     32'(bus16.validD),    32'd1);
        chk("w_pc4_wrap",  32'(bus16.pcplus4D),  32'h0);
        chk("w_instr",     32'(bus16.instrD),    32'h0000_ABCD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
